shunt_hs_frame_target: RTL and testbench

//  RTL target end of the SHUNT basic handshake: parses initiator frames (4-word header

---
 rtl/shunt_hs_frame_target_pkg.sv | 33 +++
 rtl/shunt_hs_frame_target_if.sv | 29 ++
 rtl/shunt_hs_resp_ser.sv | 45 ++++
 rtl/shunt_hs_frame_target.sv | 192 +++++++++++++++++++
 tb/tb_shunt_hs_frame_target.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shunt_hs_frame_target_pkg.sv
// shunt_hs_rtl_pkg: shared types for the SHUNT handshake frame target.
// Holds the parser state enum, the header struct, the response word indices and the NACK value.
package shunt_hs_rtl_pkg;

   // The header struct is built from words of this width, so the top's DW must equal W.
   localparam int W = 64;

   typedef enum logic [2:0] {
      H_TYPE,
      H_ID,
      H_DTYPE,
      H_NPAY,
      PAYLOAD,
      CHK,
      RESP,
      DRAIN
   } state_t;

   typedef struct packed {
      logic [W-1:0] ttype;
      logic [W-1:0] id;
      logic [W-1:0] dtype;
      logic [W-1:0] npay;
   } hdr_t;

   localparam logic [1:0] RESP_TYPE  = 2'd0;
   localparam logic [1:0] RESP_ID    = 2'd1;
   localparam logic [1:0] RESP_DTYPE = 2'd2;
   localparam logic [1:0] RESP_NPAY  = 2'd3;

   localparam logic [W-1:0] NACK = '1;

endpackage

// File: rtl/shunt_hs_frame_target_if.sv
// shunt_hs_frame_target_if: the three streams of the frame target.
// Streams: inbound words (in_*), payload to the user (pay_*), response words (resp_*).
// Modports: master = bridge/user side, slave = frame target.
interface shunt_hs_frame_target_if #(
   parameter int DW = 64
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          pay_valid;
   logic          pay_ready;
   logic [DW-1:0] pay_data;
   logic          pay_last;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_data;

   modport master (
      output in_valid, in_data, pay_ready, resp_ready,
      input  in_ready, pay_valid, pay_data, pay_last,
      input  resp_valid, resp_data
   );

   modport slave (
      input  in_valid, in_data, pay_ready, resp_ready,
      output in_ready, pay_valid, pay_data, pay_last,
      output resp_valid, resp_data
   );
endinterface

// File: rtl/shunt_hs_resp_ser.sv
// shunt_hs_resp_ser: serialises a 4-word response header under valid/ready.
// Ports: clk, rst, load + hdr (start), ready/valid/data (word stream), done (last handshake).
module shunt_hs_resp_ser
   import shunt_hs_rtl_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  hdr_t         hdr,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         done
);
   hdr_t       q;
   logic [1:0] idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q     <= '0;
         idx   <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= hdr;
         idx   <= '0;
         valid <= 1'b1;
      end else if (valid && ready) begin
         idx <= idx + 2'd1;
         if (idx == RESP_NPAY) valid <= 1'b0;
      end
   end

   always_comb begin
      data = '0;
      unique case (idx)
         RESP_TYPE:  data = q.ttype;
         RESP_ID:    data = q.id;
         RESP_DTYPE: data = q.dtype;
         RESP_NPAY:  data = q.npay;
         default:    data = '0;
      endcase
   end

   assign done = valid & ready & (idx == RESP_NPAY);
endmodule

// File: rtl/shunt_hs_frame_target.sv
// shunt_hs_frame_target: parses SHUNT initiator frames, forwards payload, returns response.
// Ports: clk, rst, bus (in/pay/resp streams), hdr_valid/hdr_* (header), err (sticky).
// Macro SHUNT_HS_TARGET_CHKSUM_EN adds an XOR checksum word after the payload.
module shunt_hs_frame_target
   import shunt_hs_rtl_pkg::*;
#(
   parameter int  DW           = W,
   parameter int  MAX_PAYLOADS = 1024,
   localparam int CW           = $clog2(MAX_PAYLOADS + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   shunt_hs_frame_target_if.slave  bus,
   output logic                    hdr_valid,
   output logic [DW-1:0]           hdr_type,
   output logic [DW-1:0]           hdr_id,
   output logic [DW-1:0]           hdr_dtype,
   output logic [CW-1:0]           hdr_npay,
   output logic                    err
);
   state_t        state, nxt;
   logic [CW-1:0] count;
   logic          pv, pl;
   logic [DW-1:0] pd;
   logic          acc, pay_fire, over, room, go_resp, rs_done;
   hdr_t          rs_hdr;
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
   logic [DW-1:0] sum;
   logic          nack;
`endif

   assign acc      = bus.in_valid & bus.in_ready;
   assign pay_fire = pv & bus.pay_ready;
   assign over     = bus.in_data > DW'(MAX_PAYLOADS);
   // Skid entry: take a word when it is empty or draining this cycle,
   // and never take more than the header announced.
   assign room     = (count != hdr_npay) & (!pv | bus.pay_ready);

   assign bus.pay_valid = pv;
   assign bus.pay_data  = pd;
   assign bus.pay_last  = pl;

   always_comb begin
      nxt          = state;
      bus.in_ready = 1'b0;
      go_resp      = 1'b0;
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
      nack         = 1'b0;
`endif
      unique case (state)
         H_TYPE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) nxt = H_ID;
         end
         H_ID: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) nxt = H_DTYPE;
         end
         H_DTYPE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) nxt = H_NPAY;
         end
         H_NPAY: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               if (over) begin
                  nxt = DRAIN;
               end else if (bus.in_data == '0) begin
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
                  nxt = CHK;
`else
                  nxt     = RESP;
                  go_resp = 1'b1;
`endif
               end else begin
                  nxt = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            bus.in_ready = room;
            if (pay_fire && pl) begin
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
               nxt = CHK;
`else
               nxt     = RESP;
               go_resp = 1'b1;
`endif
            end
         end
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
         CHK: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               nxt     = RESP;
               go_resp = 1'b1;
               nack    = bus.in_data != sum;
            end
         end
`endif
         RESP: begin
            if (rs_done) nxt = H_TYPE;
         end
         DRAIN: begin
            bus.in_ready = 1'b1;
            if (!bus.in_valid) nxt = H_TYPE;
         end
         default: nxt = H_TYPE;
      endcase
   end

   // count equals elements delivered once the response is launched
   always_comb begin
      rs_hdr.ttype = hdr_type;
      rs_hdr.id    = hdr_id;
      rs_hdr.dtype = hdr_dtype;
      rs_hdr.npay  = W'(count);
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
      if (nack) rs_hdr.npay = NACK;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= H_TYPE;
         hdr_valid <= 1'b0;
         hdr_type  <= '0;
         hdr_id    <= '0;
         hdr_dtype <= '0;
         hdr_npay  <= '0;
         count     <= '0;
         pv        <= 1'b0;
         pl        <= 1'b0;
         pd        <= '0;
         err       <= 1'b0;
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
         sum       <= '0;
`endif
      end else begin
         state     <= nxt;
         hdr_valid <= 1'b0;
         if (pay_fire) pv <= 1'b0;
         if (acc) begin
            case (state)
               H_TYPE: begin
                  hdr_type <= bus.in_data;
                  count    <= '0;
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
                  sum      <= '0;
`endif
               end
               H_ID:    hdr_id    <= bus.in_data;
               H_DTYPE: hdr_dtype <= bus.in_data;
               H_NPAY: begin
                  if (over) begin
                     err <= 1'b1;
                  end else begin
                     hdr_valid <= 1'b1;
                     hdr_npay  <= bus.in_data[CW-1:0];
                  end
               end
               PAYLOAD: begin
                  pv    <= 1'b1;
                  pd    <= bus.in_data;
                  pl    <= count == hdr_npay - 1'b1;
                  count <= count + 1'b1;
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
                  sum   <= sum ^ bus.in_data;
`endif
               end
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
               CHK: begin
                  if (nack) err <= 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   shunt_hs_resp_ser u_ser (
      .clk   (clk),
      .rst   (rst),
      .load  (go_resp),
      .hdr   (rs_hdr),
      .ready (bus.resp_ready),
      .valid (bus.resp_valid),
      .data  (bus.resp_data),
      .done  (rs_done)
   );
endmodule

// File: tb/tb_shunt_hs_frame_target.sv
// tb_shunt_hs_frame_target: directed bench for shunt_hs_frame_target.
// Drives frames through the interface and checks payload, response and error behaviour.
module tb_shunt_hs_frame_target;
   logic        clk;
   logic        rst;
   logic        hdr_valid;
   logic [63:0] hdr_type;
   logic [63:0] hdr_id;
   logic [63:0] hdr_dtype;
   logic [10:0] hdr_npay;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [63:0] pay_q[$];
   bit          last_q[$];
   logic [63:0] resp_q[$];
   int          hdr_cnt   = 0;
   int          irdy_bad  = 0;
   int          stab_bad  = 0;
   bit          held      = 0;
   logic [63:0] held_d    = '0;

   shunt_hs_frame_target_if #(.DW(64)) bus ();

   shunt_hs_frame_target dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .hdr_valid (hdr_valid),
      .hdr_type  (hdr_type),
      .hdr_id    (hdr_id),
      .hdr_dtype (hdr_dtype),
      .hdr_npay  (hdr_npay),
      .err       (err)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Inputs change at posedge+1, so what is seen at negedge is what the next edge uses.
   always @(negedge clk) begin
      if (rst) begin
         held = 0;
      end else begin
         if (bus.pay_valid && bus.pay_ready) begin
            pay_q.push_back(bus.pay_data);
            last_q.push_back(bus.pay_last);
         end
         if (bus.resp_valid && bus.resp_ready) resp_q.push_back(bus.resp_data);
         if (hdr_valid) hdr_cnt++;
         if (bus.resp_valid && bus.in_ready) irdy_bad++;
         if (held && (!bus.resp_valid || bus.resp_data !== held_d)) stab_bad++;
         held   = bus.resp_valid && !bus.resp_ready;
         held_d = bus.resp_data;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr();
      pay_q.delete();
      last_q.delete();
      resp_q.delete();
      hdr_cnt  = 0;
      irdy_bad = 0;
      stab_bad = 0;
   endtask

   task automatic send_word(input logic [63:0] w);
      bit ok;
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      ok = 0;
      n  = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_word timeout word=%0h", w);
      end
   endtask

   task automatic send_chk(input logic [63:0] c);
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
      send_word(c);
`else
      if (c === 64'hx) $display("unused");
`endif
   endtask

   task automatic end_stream();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.pay_ready  = 1'b1;
      bus.resp_ready = 1'b1;
      step(3);
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL rst in_ready got %b want 1", bus.in_ready);
      end
      total++;
      if ({hdr_valid, bus.pay_valid, bus.pay_last, bus.resp_valid, err} !== 5'b0) begin
         bad++;
         $display("FAIL rst flags got %b want 00000",
                  {hdr_valid, bus.pay_valid, bus.pay_last, bus.resp_valid, err});
      end
      total++;
      if ({hdr_type, hdr_id, hdr_dtype} !== '0 || hdr_npay !== '0) begin
         bad++; $display("FAIL rst hdr got %0h/%0h/%0h/%0h want 0",
                         hdr_type, hdr_id, hdr_dtype, hdr_npay);
      end
      total++;
      if (bus.pay_data !== '0 || bus.resp_data !== '0) begin
         bad++; $display("FAIL rst data got %0h/%0h want 0", bus.pay_data, bus.resp_data);
      end
      rst = 1'b0;
      step(1);
      clr();
   endtask

   task automatic test_basic();
      logic [63:0] ep[3] = '{64'hA, 64'hB, 64'hC};
      logic [63:0] er[4] = '{64'd1, 64'd7, 64'd2, 64'd3};
      bit          el[3] = '{0, 0, 1};
      clr();
      send_word(1); send_word(7); send_word(2); send_word(3);
      send_word(64'hA); send_word(64'hB); send_word(64'hC);
      send_chk(64'hD);
      end_stream();
      step(12);
      total++;
      if (hdr_cnt !== 1) begin bad++; $display("FAIL basic hdr_valid got %0d want 1", hdr_cnt); end
      total++;
      if ({hdr_type, hdr_id, hdr_dtype} !== {64'd1, 64'd7, 64'd2} || hdr_npay !== 11'd3) begin
         bad++; $display("FAIL basic hdr got %0h/%0h/%0h/%0h want 1/7/2/3",
                         hdr_type, hdr_id, hdr_dtype, hdr_npay);
      end
      total++;
      if (pay_q.size() != 3) begin
         bad++; $display("FAIL basic pay count got %0d want 3", pay_q.size());
      end else begin
         foreach (ep[i]) begin
            total++;
            if (pay_q[i] !== ep[i] || last_q[i] !== el[i]) begin
               bad++; $display("FAIL basic pay[%0d] got %0h/%b want %0h/%b",
                               i, pay_q[i], last_q[i], ep[i], el[i]);
            end
         end
      end
      total++;
      if (resp_q.size() != 4) begin
         bad++; $display("FAIL basic resp count got %0d want 4", resp_q.size());
      end else begin
         foreach (er[i]) begin
            total++;
            if (resp_q[i] !== er[i]) begin
               bad++; $display("FAIL basic resp[%0d] got %0h want %0h", i, resp_q[i], er[i]);
            end
         end
      end
      total++;
      if (err !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL basic idle err/in_ready got %b/%b want 0/1", err, bus.in_ready);
      end
   endtask

   task automatic test_zero();
      logic [63:0] er[4] = '{64'd1, 64'd7, 64'd2, 64'd0};
      clr();
      send_word(1); send_word(7); send_word(2); send_word(0);
`ifndef SHUNT_HS_TARGET_CHKSUM_EN
      total++;
      if (hdr_valid !== 1'b1 || bus.resp_valid !== 1'b1) begin
         bad++; $display("FAIL zero timing hdr_valid/resp_valid got %b/%b want 1/1",
                         hdr_valid, bus.resp_valid);
      end
`endif
      send_chk(0);
      end_stream();
      step(10);
      total++;
      if (pay_q.size() != 0) begin
         bad++; $display("FAIL zero pay count got %0d want 0", pay_q.size());
      end
      total++;
      if (resp_q.size() != 4) begin
         bad++; $display("FAIL zero resp count got %0d want 4", resp_q.size());
      end else begin
         foreach (er[i]) begin
            total++;
            if (resp_q[i] !== er[i]) begin
               bad++; $display("FAIL zero resp[%0d] got %0h want %0h", i, resp_q[i], er[i]);
            end
         end
      end
   endtask

   task automatic test_err();
      logic [63:0] er[4] = '{64'd3, 64'd4, 64'd5, 64'd1};
      clr();
      send_word(1); send_word(7); send_word(2); send_word(1025);
      for (int i = 0; i < 5; i++) send_word(64'd11 + 64'(i));
      end_stream();
      step(3);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err flag got %b want 1", err); end
      total++;
      if (hdr_cnt !== 0 || pay_q.size() != 0 || resp_q.size() != 0) begin
         bad++; $display("FAIL err quiet got hdr=%0d pay=%0d resp=%0d want 0/0/0",
                         hdr_cnt, pay_q.size(), resp_q.size());
      end
      send_word(3); send_word(4); send_word(5); send_word(1);
      send_word(64'h99);
      send_chk(64'h99);
      end_stream();
      step(10);
      total++;
      if (hdr_cnt !== 1 || pay_q.size() != 1) begin
         bad++; $display("FAIL err next frame got hdr=%0d pay=%0d want 1/1",
                         hdr_cnt, pay_q.size());
      end else begin
         total++;
         if (pay_q[0] !== 64'h99 || last_q[0] !== 1'b1) begin
            bad++; $display("FAIL err next pay got %0h/%b want 99/1", pay_q[0], last_q[0]);
         end
      end
      total++;
      if (resp_q.size() != 4) begin
         bad++; $display("FAIL err next resp count got %0d want 4", resp_q.size());
      end else begin
         foreach (er[i]) begin
            total++;
            if (resp_q[i] !== er[i]) begin
               bad++; $display("FAIL err next resp[%0d] got %0h want %0h", i, resp_q[i], er[i]);
            end
         end
      end
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err sticky got %b want 1", err); end
   endtask

   task automatic test_stall();
      logic [63:0] ep[4] = '{64'h10, 64'h11, 64'h12, 64'h13};
      logic [63:0] er[4] = '{64'd4, 64'd8, 64'd2, 64'd4};
      bit          el[4] = '{0, 0, 0, 1};
      bit          seen;
      clr();
      bus.resp_ready = 1'b0;
      fork
         begin
            send_word(4); send_word(8); send_word(2); send_word(4);
            foreach (ep[i]) send_word(ep[i]);
            send_chk(64'h0);
            end_stream();
         end
         begin
            for (int i = 0; i < 100 && pay_q.size() < 4; i++) begin
               bus.pay_ready = (i % 2) == 0;
               step(1);
            end
            bus.pay_ready = 1'b1;
         end
         begin
            seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
               step(1);
               seen = bus.resp_valid;
            end
            step(3);
            bus.resp_ready = 1'b1;
         end
      join
      step(10);
      total++;
      if (seen !== 1'b1) begin bad++; $display("FAIL stall resp_valid timeout got 0 want 1"); end
      total++;
      if (pay_q.size() != 4) begin
         bad++; $display("FAIL stall pay count got %0d want 4", pay_q.size());
      end else begin
         foreach (ep[i]) begin
            total++;
            if (pay_q[i] !== ep[i] || last_q[i] !== el[i]) begin
               bad++; $display("FAIL stall pay[%0d] got %0h/%b want %0h/%b",
                               i, pay_q[i], last_q[i], ep[i], el[i]);
            end
         end
      end
      total++;
      if (resp_q.size() != 4) begin
         bad++; $display("FAIL stall resp count got %0d want 4", resp_q.size());
      end else begin
         foreach (er[i]) begin
            total++;
            if (resp_q[i] !== er[i]) begin
               bad++; $display("FAIL stall resp[%0d] got %0h want %0h", i, resp_q[i], er[i]);
            end
         end
      end
      total++;
      if (stab_bad !== 0 || irdy_bad !== 0) begin
         bad++; $display("FAIL stall hold got unstable=%0d in_ready_in_resp=%0d want 0/0",
                         stab_bad, irdy_bad);
      end
   endtask

   task automatic test_rst_mid();
      logic [63:0] er[4] = '{64'd1, 64'd9, 64'd2, 64'd1};
      clr();
      send_word(1); send_word(7); send_word(2); send_word(4);
      send_word(64'h20); send_word(64'h21);
      end_stream();
      rst = 1'b1;
      #1;
      total++;
      if ({bus.pay_valid, bus.pay_last, bus.resp_valid, hdr_valid, err} !== 5'b0 ||
          bus.pay_data !== '0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL rst_mid outputs got pv=%b pl=%b rv=%b hv=%b err=%b pd=%0h ir=%b",
                         bus.pay_valid, bus.pay_last, bus.resp_valid, hdr_valid, err,
                         bus.pay_data, bus.in_ready);
      end
      total++;
      if (hdr_type !== '0 || hdr_npay !== '0) begin
         bad++; $display("FAIL rst_mid hdr got %0h/%0h want 0/0", hdr_type, hdr_npay);
      end
      step(1);
      rst = 1'b0;
      step(1);
      clr();
      send_word(1); send_word(9); send_word(2); send_word(1);
      send_word(64'hD);
      send_chk(64'hD);
      end_stream();
      step(10);
      total++;
      if (pay_q.size() != 1) begin
         bad++; $display("FAIL rst_mid pay count got %0d want 1", pay_q.size());
      end else begin
         total++;
         if (pay_q[0] !== 64'hD || last_q[0] !== 1'b1) begin
            bad++; $display("FAIL rst_mid pay got %0h/%b want d/1", pay_q[0], last_q[0]);
         end
      end
      total++;
      if (resp_q.size() != 4) begin
         bad++; $display("FAIL rst_mid resp count got %0d want 4", resp_q.size());
      end else begin
         foreach (er[i]) begin
            total++;
            if (resp_q[i] !== er[i]) begin
               bad++; $display("FAIL rst_mid resp[%0d] got %0h want %0h", i, resp_q[i], er[i]);
            end
         end
      end
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL rst_mid err got %b want 0", err); end
   endtask

`ifdef SHUNT_HS_TARGET_CHKSUM_EN
   task automatic test_chksum();
      clr();
      send_word(1); send_word(7); send_word(2); send_word(2);
      send_word(5); send_word(3); send_word(6);
      end_stream();
      step(10);
      total++;
      if (resp_q.size() != 4 || resp_q[3] !== 64'd2 || err !== 1'b0) begin
         bad++; $display("FAIL chk good got n=%0d last=%0h err=%b want 4/2/0",
                         resp_q.size(), resp_q[3], err);
      end
      clr();
      send_word(1); send_word(7); send_word(2); send_word(2);
      send_word(5); send_word(3); send_word(7);
      end_stream();
      step(10);
      total++;
      if (resp_q.size() != 4 || resp_q[3] !== {64{1'b1}} || err !== 1'b1) begin
         bad++; $display("FAIL chk nack got n=%0d last=%0h err=%b want 4/ffffffffffffffff/1",
                         resp_q.size(), resp_q[3], err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_err();
      test_stall();
      test_rst_mid();
`ifdef SHUNT_HS_TARGET_CHKSUM_EN
      test_chksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
